// File: rtl/mdma_pkg.sv
// Shared definitions for the DMA AXI read and write engines.
// Holds the state encoding, burst limits and AXI response codes.
package mdma_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam int MDMA_MAX_BURST = 16;
  localparam int AXI_LEN_W      = 4;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_ADDR = S_ADDR,
    ST_DATA = S_DATA
  } mdma_state_e;

endpackage

// File: rtl/mdma_axi_read_chk.sv
// Protocol checker for the DMA AXI read engine; observes ports only.
// Intended to be instantiated alongside mdma_axi_read in a simulation environment.
module mdma_axi_read_chk #(
  parameter int ADDR_W = 32
) (
  input logic              aclk,
  input logic              areset,
  input logic              free,
  input logic              arvalid,
  input logic              arready,
  input logic [ADDR_W-1:0] araddr,
  input logic [3:0]        arlen,
  input logic              rvalid,
  input logic              rready,
  input logic              fifo_wen
);

  // An idle engine drives neither AXI channel
  a_idle_quiet: assert property (@(posedge aclk) disable iff (areset)
    free |-> (!arvalid && !rready));

  // Every FIFO push corresponds to exactly one R handshake
  a_push_is_beat: assert property (@(posedge aclk) disable iff (areset)
    fifo_wen == (rvalid && rready));

  // AR request stays put until the slave takes it
  a_ar_hold: assert property (@(posedge aclk) disable iff (areset)
    (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arlen)));

endmodule

// File: rtl/mdma_axi_read.sv
// DMA read-side AXI master: one AR burst per command, every R beat pushed into the data FIFO.
// Burst length is tracked by a down-counter; rlast and rresp are only checked and flagged on err.
module mdma_axi_read
  import mdma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 5,
  parameter int MAX_BURST = MDMA_MAX_BURST
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 valid,
  input  logic [ADDR_W-1:0]    head_addr,
  input  logic [LEN_W-1:0]     burst_len,
  output logic                 free,
  output logic                 err,
  output logic                 fifo_wen,
  output logic [DATA_W-1:0]    fifo_wdata,
  input  logic                 fifo_full,
  output logic [ADDR_W-1:0]    araddr,
  output logic [AXI_LEN_W-1:0] arlen,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [DATA_W-1:0]    rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready
);

  mdma_state_e          state_r;
  logic [LEN_W-1:0]     remain_r;
  logic                 free_r;
  logic                 arvalid_r;
  logic                 err_r;
  logic [ADDR_W-1:0]    araddr_r;
  logic [AXI_LEN_W-1:0] arlen_r;

  logic cmd_ok_s;
  logic rready_s;
  logic beat_s;
  logic last_s;
  logic beat_bad_s;

  // Command legality, R handshake and per-beat error detection
  always_comb begin
    cmd_ok_s   = valid && (burst_len != {LEN_W{1'b0}}) && (burst_len <= LEN_W'(MAX_BURST));
    rready_s   = (state_r == ST_DATA) && !fifo_full;
    beat_s     = rready_s && rvalid;
    last_s     = (remain_r == LEN_W'(1));
    beat_bad_s = (rresp != AXI_RESP_OKAY) || (rlast != last_s);
  end

  // Burst FSM with registered AR request, status and error pulse
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r   <= ST_IDLE;
      remain_r  <= {LEN_W{1'b0}};
      free_r    <= 1'b1;
      arvalid_r <= 1'b0;
      err_r     <= 1'b0;
      araddr_r  <= {ADDR_W{1'b0}};
      arlen_r   <= {AXI_LEN_W{1'b0}};
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_ok_s) begin
            araddr_r  <= head_addr;
            arlen_r   <= AXI_LEN_W'(burst_len - LEN_W'(1));
            remain_r  <= burst_len;
            free_r    <= 1'b0;
            arvalid_r <= 1'b1;
            state_r   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_s) begin
            remain_r <= remain_r - LEN_W'(1);
            err_r    <= beat_bad_s;
            // The counter, not rlast, decides where the burst ends
            if (last_s) begin
              free_r  <= 1'b1;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          free_r    <= 1'b1;
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign free       = free_r;
  assign err        = err_r;
  assign arvalid    = arvalid_r;
  assign araddr     = araddr_r;
  assign arlen      = arlen_r;
  assign rready     = rready_s;
  assign fifo_wen   = beat_s;
  assign fifo_wdata = rdata;

endmodule

// File: tb/tb_mdma_axi_read.sv
// Self-checking bench for mdma_axi_read: directed bursts, transaction-level model and FIFO scoreboard.
module tb_mdma_axi_read;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 5;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] head_addr = '0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic              free;
  logic              err;
  logic              fifo_wen;
  logic [DATA_W-1:0] fifo_wdata;
  logic              fifo_full = 1'b0;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic [1:0]        rresp = 2'b00;
  logic              rlast = 1'b0;
  logic              rvalid = 1'b0;
  logic              rready;

  mdma_axi_read #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(16)) dut (
    .aclk(aclk), .areset(areset), .valid(valid), .head_addr(head_addr), .burst_len(burst_len),
    .free(free), .err(err), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  mdma_axi_read_chk #(.ADDR_W(ADDR_W)) chk (
    .aclk(aclk), .areset(areset), .free(free), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arlen(arlen), .rvalid(rvalid), .rready(rready), .fifo_wen(fifo_wen)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int stall_cnt = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  // Transaction-level model: engine busy, AR outstanding, beats left, last command
  bit          m_busy;
  bit          m_ar_pend;
  bit          m_err;
  bit          m_beat;
  bit          m_idle;
  int          m_remain;
  logic [31:0] m_addr;
  logic [3:0]  m_arlen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: checks outputs on every falling edge, then advances the model
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        check_bit("rst_free", free, 1'b1);
        check_bit("rst_arvalid", arvalid, 1'b0);
        check_bit("rst_rready", rready, 1'b0);
        check_bit("rst_fifo_wen", fifo_wen, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_arlen", 64'(arlen), 64'd0);
        m_busy = 1'b0; m_ar_pend = 1'b0; m_err = 1'b0;
        m_remain = 0; m_addr = 32'd0; m_arlen = 4'd0;
      end else begin
        m_beat = m_busy && !m_ar_pend && rvalid && !fifo_full;
        check_bit("free", free, !m_busy);
        check_bit("arvalid", arvalid, m_ar_pend);
        check("araddr", 64'(araddr), 64'(m_addr));
        check("arlen", 64'(arlen), 64'(m_arlen));
        check_bit("err", err, m_err);
        check_bit("rready", rready, m_busy && !m_ar_pend && !fifo_full);
        check_bit("fifo_wen", fifo_wen, m_beat);
        if (fifo_wen) got_q.push_back(fifo_wdata);
        if (err) err_seen++;
        m_idle = !m_busy;
        m_err = 1'b0;
        if (m_beat) begin
          m_err = (rresp != 2'b00) || (rlast != (m_remain == 1));
          m_remain--;
          if (m_remain == 0) m_busy = 1'b0;
        end else if (m_ar_pend && arready) begin
          m_ar_pend = 1'b0;
        end
        if (m_idle && valid && burst_len >= 5'd1 && burst_len <= 5'd16) begin
          m_busy = 1'b1; m_ar_pend = 1'b1;
          m_remain = int'(burst_len);
          m_addr = head_addr;
          m_arlen = 4'(int'(burst_len) - 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [4:0] len);
    valid = 1'b1; head_addr = addr; burst_len = len;
    tick();
    valid = 1'b0;
  endtask

  // AXI slave for one burst: AR handshake after ar_delay, then beats seed+i with optional
  // bad response, early rlast, FIFO backpressure, abort, or a stray command during beat 0
  task automatic run_burst(input int len, input int ar_delay, input int bad_beat, input int last_beat,
                           input int full_after, input int full_cycles, input int abort_after,
                           input bit poke, input logic [63:0] seed);
    int waited;
    int full_left;
    bit acc;
    waited = 0;
    while (!arvalid && waited < 20) begin
      tick();
      waited++;
    end
    check_bit("ar_wait", arvalid, 1'b1);
    repeat (ar_delay) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    full_left = 0;
    stall_cnt = 0;
    for (int i = 0; i < len; i++) begin
      if (abort_after != 0 && i == abort_after) break;
      rvalid = 1'b1;
      rdata  = seed + 64'(i);
      rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (i == last_beat) || (i == len - 1);
      valid  = poke && (i == 0);
      head_addr = 32'hDEAD_0000; burst_len = 5'd5;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        fifo_full = (full_left > 0);
        #1;
        acc = rready;
        if (!rready) stall_cnt++;
        if (full_left > 0) full_left--;
        tick();
      end
      valid = 1'b0;
      check_bit("beat_accept", acc, 1'b1);
      if (acc) exp_q.push_back(seed + 64'(i));
      if (i + 1 == full_after) full_left = full_cycles;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; fifo_full = 1'b0;
  endtask

  task automatic finish_test(input int exp_pushes, input int exp_err);
    repeat (2) tick();
    check("push_count", 64'(got_q.size()), 64'(exp_pushes));
    check("push_vs_sent", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("push_data", got_q[i], exp_q[i]);
    check("err_count", 64'(err_seen), 64'(exp_err));
    check_bit("free_end", free, 1'b1);
    got_q.delete();
    exp_q.delete();
    err_seen = 0;
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    tick();

    // Basic 4-beat burst
    send_cmd(32'h0000_1000, 5'd4);
    check_bit("t1_arvalid", arvalid, 1'b1);
    check("t1_arlen", 64'(arlen), 64'd3);
    check("t1_araddr", 64'(araddr), 64'h1000);
    check_bit("t1_busy", free, 1'b0);
    run_burst(4, 2, -1, 3, 0, 0, 0, 1'b0, 64'h1111_0000_0000_0000);
    check_bit("t1_free_next", free, 1'b1);
    finish_test(4, 0);

    // Backpressure: FIFO full for 3 cycles after beat 2
    send_cmd(32'h0000_2000, 5'd8);
    run_burst(8, 0, -1, 7, 2, 3, 0, 1'b0, 64'h2222_0000_0000_0000);
    check("t2_stall", 64'(stall_cnt), 64'd3);
    finish_test(8, 0);

    // Illegal lengths are ignored
    send_cmd(32'h0000_3000, 5'd0);
    check_bit("t3_len0_free", free, 1'b1);
    check_bit("t3_len0_ar", arvalid, 1'b0);
    send_cmd(32'h0000_3000, 5'd17);
    check_bit("t3_len17_free", free, 1'b1);
    check_bit("t3_len17_ar", arvalid, 1'b0);

    // Commands during an active burst are ignored
    send_cmd(32'h0000_4000, 5'd2);
    valid = 1'b1; head_addr = 32'h0000_5000; burst_len = 5'd3;
    tick();
    valid = 1'b0;
    check("t3_addr_hold", 64'(araddr), 64'h4000);
    check("t3_len_hold", 64'(arlen), 64'd1);
    run_burst(2, 1, -1, 1, 0, 0, 0, 1'b1, 64'h3333_0000_0000_0000);
    check("t3_addr_after", 64'(araddr), 64'h4000);
    finish_test(2, 0);

    // Bad rresp on beat 2 of 4
    send_cmd(32'h0000_6000, 5'd4);
    run_burst(4, 0, 1, 3, 0, 0, 0, 1'b0, 64'h4444_0000_0000_0000);
    finish_test(4, 1);

    // Early rlast on beat 3 of 4
    send_cmd(32'h0000_7000, 5'd4);
    run_burst(4, 0, -1, 2, 0, 0, 0, 1'b0, 64'h5555_0000_0000_0000);
    finish_test(4, 1);

    // Single beat and maximum length
    send_cmd(32'h0000_8000, 5'd1);
    check("t5_arlen1", 64'(arlen), 64'd0);
    run_burst(1, 0, -1, 0, 0, 0, 0, 1'b0, 64'h6666_0000_0000_0000);
    finish_test(1, 0);
    send_cmd(32'h0000_9000, 5'd16);
    check("t5_arlen16", 64'(arlen), 64'd15);
    run_burst(16, 1, -1, 15, 0, 0, 0, 1'b0, 64'h7777_0000_0000_0000);
    finish_test(16, 0);

    // Asynchronous reset after beat 2 of 8
    send_cmd(32'h0000_A000, 5'd8);
    run_burst(8, 0, -1, 7, 0, 0, 2, 1'b0, 64'h8888_0000_0000_0000);
    rvalid = 1'b1; rdata = 64'h8888_0000_0000_0002;
    #1;
    check_bit("t6_beat_live", fifo_wen, 1'b1);
    areset = 1'b1;
    #1;
    check_bit("t6_arvalid", arvalid, 1'b0);
    check_bit("t6_rready", rready, 1'b0);
    check_bit("t6_fifo_wen", fifo_wen, 1'b0);
    check_bit("t6_free", free, 1'b1);
    rvalid = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    tick();
    finish_test(2, 0);
    send_cmd(32'h0000_B000, 5'd2);
    check("t6_new_addr", 64'(araddr), 64'hB000);
    run_burst(2, 0, -1, 1, 0, 0, 0, 1'b0, 64'h9999_0000_0000_0000);
    finish_test(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
